mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single-port program/data RAM between the CPU memory path (PC-addressed fetch plus load/store via `msel`/`mwrite`) and a program-loader port used to fill or inspect memory over a debug link. It sits between those requesters and the RAM and decides each cycle which one owns the RAM. It inserts wait states into the losing requester and returns read data with the RAM's fixed one-cycle latency. A loader lock lets a burst program load run without interleaved CPU accesses.

## Interface
- `DATA_W`, default 16: RAM word width.
- `ADDR_W`, default 8: RAM address width.

Ports:
- `clk`  in  1: rising-edge clock; the only clock.
- `reset`  in  1: synchronous, active-high.
- `cpu_req`  in  1: CPU requests an access this cycle.
- `cpu_we`  in  1: CPU access is a write.
- `cpu_addr`  in  ADDR_W: CPU address.
- `cpu_wdata`  in  DATA_W: CPU write data.
- `cpu_gnt`  out  1: CPU access accepted this cycle.
- `cpu_rvalid`  out  1: CPU read data valid.
- `cpu_rdata`  out  DATA_W: CPU read data.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_gnt`, `ldr_rvalid`, `ldr_rdata`: loader equivalents of the CPU ports, same widths and directions.
- `ldr_lock`  in  1: loader requests exclusive ownership.
- `ram_addr`  out  ADDR_W: RAM address, driving both `readAddress` and `writeAddress`.
- `ram_we`  out  1: RAM write enable.
- `ram_wdata`  out  DATA_W: RAM write data.
- `ram_rdata`  in  DATA_W: RAM read data, valid one cycle after its address.

## Operation
- **FSM states:** `ARB` and `LOCKED`. Reset enters `ARB`.
- **`ARB`, single request:** a lone request is granted in the same cycle. `gnt` is combinational from `req` and registered state.
- **`ARB`, both requesting:** the winner is set by the arbitration policy (see Configuration). The loser's `gnt` is 0 and it must hold `req`, `we`, `addr` and `wdata` stable until granted.
- **Entering `LOCKED`:** a loader grant with `ldr_lock`=1 moves the FSM to `LOCKED` next cycle.
- **In `LOCKED`:**
  - `cpu_gnt` is 0 unconditionally, even when `ldr_req`=0.
  - `ldr_gnt` = `ldr_req`.
  - `ldr_lock`=0 sampled on any cycle returns the FSM to `ARB` next cycle.
- **RAM drive:**
  - `ram_addr`/`ram_wdata` come from the granted port. With no grant they hold the last granted values.
  - `ram_we` = granted port's `we`; 0 with no grant.
- **Read tracking:** a granted read (we=0) sets a registered owner tag and a read-pending flag. Next cycle the owner's `rvalid`=1 and the other port's `rvalid`=0. Writes never produce `rvalid`.
- **Read data:** `cpu_rdata` and `ldr_rdata` both connect to `ram_rdata`. They are meaningful only while the respective `rvalid` is asserted.
- **Invariants:**
  - At most one `gnt` is high per cycle.
  - At most one `rvalid` is high per cycle.
- **Reset values:** `cpu_gnt`/`ldr_gnt`=0 while `reset` is high; `cpu_rvalid`/`ldr_rvalid`=0; `ram_we`=0; `ram_addr`=0; `ram_wdata`=0; state=`ARB`; last-winner=CPU.
- **Reset mid-operation:** a pending read is discarded and no `rvalid` appears in the cycle after reset deasserts. A lock is cleared.

## Timing
- **Grant-to-data latency:** exactly 1 cycle. A read granted in cycle N has `rvalid`/`rdata` in cycle N+1.
- **Throughput:** one access per cycle, back-to-back, from either port.
- **Write commit:** a write granted in cycle N is committed at the clock edge ending cycle N. A read of the same address granted in cycle N+1 returns the new data.
- **Lock release:** `ldr_lock` deasserted in cycle N allows a CPU grant in cycle N+1 at the earliest.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on contention in `ARB`, the port that did not win the previous contended cycle wins. The last-winner register updates only on grants.
- Undefined: fixed priority, loader always wins contention. The last-winner register is not built.

## Structure
- **Shared package `mem_arb_pkg`:**
  - State enum (`ARB`, `LOCKED`).
  - Port-id constants `PORT_CPU`=0, `PORT_LDR`=1.
  - Default widths 16/8, matching the RAM instance parameters.
- **Sub-module `mem_arb_pick`:** one combinational sub-module holding the grant decision. Inputs are the two `req`s, the state and last-winner; outputs are the grant vector. The policy macro is confined to it.

## Test plan
- **Single-port read:** after reset, CPU read of addr 0x05 holding 0x1234 -> `cpu_gnt`=1 in the request cycle; `cpu_rvalid`=1 with `cpu_rdata`=0x1234 next cycle; `ldr_rvalid`=0.
- **Contention:** both ports request reads of 0x10/0x20 in the same cycle -> fixed priority: loader granted first, CPU granted next cycle. Round-robin: same first cycle (last-winner resets to CPU), then strictly alternating over 4 contended cycles.
- **Write-then-read:** loader writes 0xBEEF to 0x7F, CPU reads 0x7F next cycle -> `cpu_rdata`=0xBEEF.
- **Lock burst:** loader asserts `ldr_lock` and writes 0x00-0x03 with gaps while CPU requests continuously -> `cpu_gnt`=0 throughout. `cpu_gnt`=1 the cycle after `ldr_lock` drops.
- **Reset mid-read:** `reset` asserted in the cycle after a granted read -> no `rvalid`; state `ARB`; `ram_we`=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the program/data RAM arbiter.
// Optional feature macro used by the arbiter: MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_LDR = 1'b1;

   // Must match the RAM instance parameters.
   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision for the two RAM requesters.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin contention; otherwise the loader always wins.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic       cpu_req_i,
   input  logic       ldr_req_i,
   input  logic       state_i,
   input  logic       last_win_i,
   output logic [1:0] gnt_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic winner;
   assign winner = (last_win_i == PORT_CPU) ? PORT_LDR : PORT_CPU;
`else
   logic unused_last_win;
   assign unused_last_win = last_win_i;
`endif

   always_comb begin
      gnt_o = '0;
      if (arb_state_e'(state_i) == LOCKED) begin
         // The CPU is shut out for the whole lock, even on idle loader cycles.
         gnt_o[PORT_LDR] = ldr_req_i;
      end else if (cpu_req_i && ldr_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         gnt_o[winner] = 1'b1;
`else
         gnt_o[PORT_LDR] = 1'b1;
`endif
      end else begin
         gnt_o[PORT_CPU] = cpu_req_i;
         gnt_o[PORT_LDR] = ldr_req_i;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port program/data RAM between the CPU and the program loader.
// MEM_ARB_ROUND_ROBIN_EN: round-robin contention instead of fixed loader priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_gnt,
   output logic              ldr_rvalid,
   output logic [DATA_W-1:0] ldr_rdata,
   input  logic              ldr_lock,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   arb_state_e        state_q, state_d;
   logic              last_win;
   logic [1:0]        gnt_raw;
   logic              rd_pend_q, rd_pend_d;
   logic              rd_own_q, rd_own_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   mem_arb_pick u_pick (
      .cpu_req_i  (cpu_req),
      .ldr_req_i  (ldr_req),
      .state_i    (state_q),
      .last_win_i (last_win),
      .gnt_o      (gnt_raw)
   );

   assign cpu_gnt = gnt_raw[PORT_CPU] & ~reset;
   assign ldr_gnt = gnt_raw[PORT_LDR] & ~reset;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_win_q, last_win_d;

   always_comb begin
      last_win_d = last_win_q;
      if (state_q == ARB && cpu_req && ldr_req && (cpu_gnt || ldr_gnt))
         last_win_d = ldr_gnt ? PORT_LDR : PORT_CPU;
   end

   always_ff @(posedge clk) begin
      if (reset) last_win_q <= PORT_CPU;
      else       last_win_q <= last_win_d;
   end

   assign last_win = last_win_q;
`else
   assign last_win = PORT_CPU;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB:     if (ldr_gnt && ldr_lock) state_d = LOCKED;
         LOCKED:  if (!ldr_lock)           state_d = ARB;
         default: state_d = ARB;
      endcase
   end

   // RAM drive: the granted port passes straight through; idle cycles hold the last address/data.
   always_comb begin
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
      ram_we    = 1'b0;
      if (cpu_gnt) begin
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
         ram_we    = cpu_we;
      end else if (ldr_gnt) begin
         ram_addr  = ldr_addr;
         ram_wdata = ldr_wdata;
         ram_we    = ldr_we;
      end
   end

   always_comb begin
      rd_pend_d = (cpu_gnt && !cpu_we) || (ldr_gnt && !ldr_we);
      rd_own_d  = rd_own_q;
      if (ldr_gnt)      rd_own_d = PORT_LDR;
      else if (cpu_gnt) rd_own_d = PORT_CPU;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ARB;
         rd_pend_q <= 1'b0;
         rd_own_q  <= PORT_CPU;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         rd_pend_q <= rd_pend_d;
         rd_own_q  <= rd_own_d;
         if (cpu_gnt || ldr_gnt) begin
            addr_q  <= ram_addr;
            wdata_q <= ram_wdata;
         end
      end
   end

   // A read pending across a reset edge must not surface while reset is still high.
   assign cpu_rvalid = rd_pend_q && !reset && (rd_own_q == PORT_CPU);
   assign ldr_rvalid = rd_pend_q && !reset && (rd_own_q == PORT_LDR);
   assign cpu_rdata  = ram_rdata;
   assign ldr_rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural one-cycle-latency RAM.
module tb_mem_arbiter;

   localparam int DW = 16;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
   logic [AW-1:0] cpu_addr, ldr_addr, ram_addr;
   logic [DW-1:0] cpu_wdata, ldr_wdata, ram_wdata, ram_rdata;
   logic [DW-1:0] cpu_rdata, ldr_rdata;
   logic          cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, ram_we;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   int n_chk  = 0;
   int n_fail = 0;
   bit exp_l;

   mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
      .ldr_lock(ldr_lock),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Each step changes inputs on the falling edge and samples 1 time unit later.
   task automatic step(input logic c_req, input logic c_we, input logic [AW-1:0] c_addr,
                       input logic l_req, input logic l_we, input logic [AW-1:0] l_addr,
                       input logic [DW-1:0] l_wdata, input logic lock);
      @(negedge clk);
      cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = 16'h0;
      ldr_req = l_req; ldr_we = l_we; ldr_addr = l_addr; ldr_wdata = l_wdata;
      ldr_lock = lock;
      #1;
      chk("one_gnt", 32'(cpu_gnt & ldr_gnt), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0; ldr_lock = 0;
      @(negedge clk);
      @(negedge clk);

      // Reset state while a CPU request is presented.
      step(1, 0, 8'h05, 0, 0, 8'h00, 16'h0, 0);
      chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
      chk("rst_ldr_gnt", 32'(ldr_gnt), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      chk("rst_ram_wdata", 32'(ram_wdata), 0);
      chk("rst_rvalid", 32'({cpu_rvalid, ldr_rvalid}), 0);

      // Preload via the loader.
      @(negedge clk); reset = 1'b0;
      cpu_req = 0; ldr_req = 1; ldr_we = 1; ldr_addr = 8'h05; ldr_wdata = 16'h1234;
      #1;
      chk("pre_gnt", 32'(ldr_gnt), 1);
      chk("pre_we", 32'(ram_we), 1);
      chk("pre_addr", 32'(ram_addr), 32'h05);
      step(0, 0, 8'h00, 1, 1, 8'h10, 16'hAAAA, 0);
      step(0, 0, 8'h00, 1, 1, 8'h20, 16'h5555, 0);
      chk("pre_wdata", 32'(ram_wdata), 32'h5555);

      // Single-port CPU read.
      step(1, 0, 8'h05, 0, 0, 8'h00, 16'h0, 0);
      chk("rd_cpu_gnt", 32'(cpu_gnt), 1);
      chk("rd_ldr_gnt", 32'(ldr_gnt), 0);
      chk("rd_addr", 32'(ram_addr), 32'h05);
      chk("rd_we", 32'(ram_we), 0);
      chk("wr_no_rvalid", 32'(ldr_rvalid), 0);
      step(0, 0, 8'h00, 0, 0, 8'h00, 16'h0, 0);
      chk("rd_cpu_rvalid", 32'(cpu_rvalid), 1);
      chk("rd_cpu_rdata", 32'(cpu_rdata), 32'h1234);
      chk("rd_ldr_rvalid", 32'(ldr_rvalid), 0);
      chk("idle_addr_hold", 32'(ram_addr), 32'h05);
      chk("idle_we", 32'(ram_we), 0);

      // Contention: loader first in both policies, then the held CPU request.
      step(1, 0, 8'h10, 1, 0, 8'h20, 16'h0, 0);
      chk("ct_ldr_gnt", 32'(ldr_gnt), 1);
      chk("ct_cpu_gnt", 32'(cpu_gnt), 0);
      chk("ct_addr", 32'(ram_addr), 32'h20);
      step(1, 0, 8'h10, 0, 0, 8'h00, 16'h0, 0);
      chk("ct2_cpu_gnt", 32'(cpu_gnt), 1);
      chk("ct2_addr", 32'(ram_addr), 32'h10);
      chk("ct2_ldr_rvalid", 32'(ldr_rvalid), 1);
      chk("ct2_ldr_rdata", 32'(ldr_rdata), 32'h5555);
      chk("ct2_cpu_rvalid", 32'(cpu_rvalid), 0);

      // Four contended cycles back-to-back.
      for (int k = 0; k < 4; k++) begin
         step(1, 0, 8'h05, 1, 0, 8'h20, 16'h0, 0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
         exp_l = (k % 2) == 1;
`else
         exp_l = 1'b1;
`endif
         chk("rr_ldr_gnt", 32'(ldr_gnt), 32'(exp_l));
         chk("rr_cpu_gnt", 32'(cpu_gnt), 32'(!exp_l));
         if (k == 0) begin
            chk("rr_prev_cpu_rdata", 32'(cpu_rdata), 32'hAAAA);
            chk("rr_prev_cpu_rvalid", 32'(cpu_rvalid), 1);
         end
      end
      step(0, 0, 8'h00, 0, 0, 8'h00, 16'h0, 0);
      chk("rr_last_ldr_rvalid", 32'(ldr_rvalid), 1);
      chk("rr_last_rdata", 32'(ldr_rdata), 32'h5555);

      // Write-then-read forwarding through the RAM.
      step(0, 0, 8'h00, 1, 1, 8'h7F, 16'hBEEF, 0);
      chk("wr_gnt", 32'(ldr_gnt), 1);
      chk("wr_we", 32'(ram_we), 1);
      chk("wr_wdata", 32'(ram_wdata), 32'hBEEF);
      step(1, 0, 8'h7F, 0, 0, 8'h00, 16'h0, 0);
      chk("wr_rd_gnt", 32'(cpu_gnt), 1);
      chk("wr_rd_norv", 32'({cpu_rvalid, ldr_rvalid}), 0);
      step(0, 0, 8'h00, 0, 0, 8'h00, 16'h0, 0);
      chk("wr_rd_rvalid", 32'(cpu_rvalid), 1);
      chk("wr_rd_rdata", 32'(cpu_rdata), 32'hBEEF);

      // Locked burst with gaps while the CPU requests continuously.
      step(0, 0, 8'h00, 1, 1, 8'h00, 16'h0100, 1);
      chk("lk0_ldr_gnt", 32'(ldr_gnt), 1);
      step(1, 0, 8'h05, 0, 0, 8'h00, 16'h0, 1);
      chk("lk1_cpu_gnt", 32'(cpu_gnt), 0);
      step(1, 0, 8'h05, 1, 1, 8'h01, 16'h0101, 1);
      chk("lk2_cpu_gnt", 32'(cpu_gnt), 0);
      chk("lk2_ldr_gnt", 32'(ldr_gnt), 1);
      step(1, 0, 8'h05, 0, 0, 8'h00, 16'h0, 1);
      chk("lk3_cpu_gnt", 32'(cpu_gnt), 0);
      step(1, 0, 8'h05, 1, 1, 8'h02, 16'h0102, 1);
      chk("lk4_cpu_gnt", 32'(cpu_gnt), 0);
      step(1, 0, 8'h05, 1, 1, 8'h03, 16'h0103, 1);
      chk("lk5_cpu_gnt", 32'(cpu_gnt), 0);
      chk("lk5_wdata", 32'(ram_wdata), 32'h0103);
      step(1, 0, 8'h05, 0, 0, 8'h00, 16'h0, 0);
      chk("lk_drop_cpu_gnt", 32'(cpu_gnt), 0);
      step(1, 0, 8'h05, 0, 0, 8'h00, 16'h0, 0);
      chk("lk_rel_cpu_gnt", 32'(cpu_gnt), 1);
      chk("lk_rel_addr", 32'(ram_addr), 32'h05);
      step(0, 0, 8'h00, 0, 0, 8'h00, 16'h0, 0);
      chk("lk_rel_rvalid", 32'(cpu_rvalid), 1);
      chk("lk_rel_rdata", 32'(cpu_rdata), 32'h1234);

      // Reset during a pending locked read.
      step(0, 0, 8'h00, 1, 0, 8'h7F, 16'h0, 1);
      chk("rm_ldr_gnt", 32'(ldr_gnt), 1);
      @(negedge clk);
      reset = 1'b1; ldr_req = 0;
      #1;
      chk("rm_rvalid", 32'({cpu_rvalid, ldr_rvalid}), 0);
      chk("rm_ram_we", 32'(ram_we), 0);
      @(negedge clk);
      reset = 1'b0; cpu_req = 1; cpu_we = 0; cpu_addr = 8'h7F;
      #1;
      chk("rm_post_rvalid", 32'({cpu_rvalid, ldr_rvalid}), 0);
      chk("rm_unlocked_cpu_gnt", 32'(cpu_gnt), 1);
      step(0, 0, 8'h00, 0, 0, 8'h00, 16'h0, 0);
      chk("rm_cpu_rvalid", 32'(cpu_rvalid), 1);
      chk("rm_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
